// File: rtl/im_boot_loader.sv
// Instruction-memory port arbiter: passes CPU fetches through in RUN and lets a
// byte-serial loader write a length-prefixed program into IM words 0..N-1.
module im_boot_loader #(
    parameter int unsigned IM_AW = 11,
    parameter int unsigned CNT_W = 16
) (
    input  logic             cpu_clk_50M,
    input  logic             cpu_rst_n,
    input  logic             load_start,
    input  logic [7:0]       byte_data,
    input  logic             byte_valid,
    output logic             byte_ready,
    input  logic             if_req,
    input  logic [IM_AW-1:0] if_addr,
    output logic [31:0]      if_inst,
    output logic             if_valid,
    output logic             cpu_stall,
    output logic             load_done,
    output logic             load_err,
    output logic [IM_AW-1:0] imaddr,
    output logic             imwe,
    output logic [31:0]      imdin,
    output logic             imce,
    input  logic [31:0]      inst
);

    typedef enum logic [2:0] {StRun, StHdr0, StHdr1, StData, StWrite, StDone} state_e;

    state_e           state_q;
    logic [CNT_W-1:0] n_q;
    logic [CNT_W:0]   wr_ptr_q;
    logic [1:0]       byte_cnt_q;
    logic [31:0]      word_q;

    logic [CNT_W-1:0] n_full;
    logic [CNT_W:0]   wr_ptr_nxt;
    logic             hdr_too_big;
    logic             wr_in_range;

    // Header low byte completes the count in the same cycle it is accepted.
    assign n_full      = {n_q[CNT_W-1:8], byte_data};
    assign wr_ptr_nxt  = wr_ptr_q + {{CNT_W{1'b0}}, 1'b1};
    assign hdr_too_big = 32'(n_full) > (32'd1 << IM_AW);
    assign wr_in_range = 32'(wr_ptr_q) < (32'd1 << IM_AW);

    assign cpu_stall  = (state_q != StRun);
    assign byte_ready = (state_q == StHdr0) || (state_q == StHdr1) || (state_q == StData);
    assign if_inst    = inst;
    assign imdin      = word_q;

    always_comb begin
        imce   = 1'b0;
        imwe   = 1'b0;
        imaddr = '0;
        if (state_q == StRun) begin
            imce   = if_req;
            imaddr = if_addr;
        end else if (state_q == StWrite) begin
            imce   = 1'b1;
            imwe   = wr_in_range;
            imaddr = wr_ptr_q[IM_AW-1:0];
        end
    end

    always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            state_q    <= StRun;
            n_q        <= '0;
            wr_ptr_q   <= '0;
            byte_cnt_q <= '0;
            word_q     <= '0;
            if_valid   <= 1'b0;
            load_done  <= 1'b0;
            load_err   <= 1'b0;
        end else begin
            if_valid  <= 1'b0;
            load_done <= 1'b0;
            unique case (state_q)
                StRun: begin
                    if_valid <= if_req;
                    if (load_start) begin
                        state_q    <= StHdr0;
                        load_err   <= 1'b0;
                        wr_ptr_q   <= '0;
                        byte_cnt_q <= '0;
                    end
                end
                StHdr0: begin
                    if (byte_valid) begin
                        n_q[CNT_W-1:8] <= byte_data;
                        state_q        <= StHdr1;
                    end
                end
                StHdr1: begin
                    if (byte_valid) begin
                        n_q <= n_full;
                        if (hdr_too_big) load_err <= 1'b1;
                        if (n_full == '0) begin
                            state_q   <= StDone;
                            load_done <= 1'b1;
                        end else begin
                            state_q <= StData;
                        end
                    end
                end
                StData: begin
                    if (byte_valid) begin
                        // Shift-in packs the first byte of each group into word[31:24].
                        word_q     <= {word_q[23:0], byte_data};
                        byte_cnt_q <= byte_cnt_q + 2'd1;
                        if (byte_cnt_q == 2'd3) state_q <= StWrite;
                    end
                end
                StWrite: begin
                    wr_ptr_q <= wr_ptr_nxt;
                    if (wr_ptr_nxt == {1'b0, n_q}) begin
                        state_q   <= StDone;
                        load_done <= 1'b1;
                    end else begin
                        state_q <= StData;
                    end
                end
                StDone:  state_q <= StRun;
                default: state_q <= StRun;
            endcase
        end
    end

endmodule
